// File: rtl/divu_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_defs
// Definitions shared by the combinational ALU and the sequential divider:
//   - 6-bit function codes decoded by the ALU datapath
//   - state encoding of the divider control FSM
// -----------------------------------------------------------------------------
package alu_defs;

    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_DIVU = 6'd27;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divu_unit_if.sv
// -----------------------------------------------------------------------------
// divu_unit_if
// Operand / function-code bus into the divider and its result bus back out.
//   dataA, dataB : dividend, divisor
//   signal       : function code (only DIVU is acted on)
//   start        : request strobe
//   busy, done   : status (done is a one-cycle pulse)
//   dz           : divide-by-zero flag of the last completed operation
//   hi, lo       : remainder, quotient
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface divu_unit_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       signal;
    logic             start;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output dataA, dataB, signal, start,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  dataA, dataB, signal, start,
        output busy, done, dz, hi, lo
    );

endinterface

// File: rtl/divu_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on the {rem, q} pair:
// shift left by one, then subtract the divisor if it fits and record the
// outcome in the new quotient LSB.
//   rem, q, divisor : current working state
//   rem_next, q_next: state after one step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] rem_sh;
    logic           fits;

    // The remainder is always below the divisor before a step, so its MSB is
    // zero and dropping it in the shift loses nothing.
    assign rem_sh   = {rem[WIDTH-1:0], q[WIDTH-1]};
    assign fits     = (rem_sh >= {1'b0, divisor});
    assign rem_next = fits ? (rem_sh - {1'b0, divisor}) : rem_sh;
    assign q_next   = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/divu_unit.sv
// -----------------------------------------------------------------------------
// divu_unit
// Sequential unsigned divider (DIVU) beside the combinational ALU. Performs a
// one-bit-per-cycle restoring division; quotient goes to lo, remainder to hi.
// Divide-by-zero completes immediately with lo=all-ones, hi=dividend, dz=1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : divu_unit_if.slave (operands, function code, start, results)
// -----------------------------------------------------------------------------
module divu_unit
    import alu_defs::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [5:0] DIVU  = FN_DIVU
) (
    input  logic        clk,
    input  logic        rst_n,
    divu_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;

    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic accept;

    // start is only honoured outside RUN and only for the DIVU code.
    assign accept = bus.start && (bus.signal == DIVU) && (state != S_RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q        (q),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    // NOTE: all state, including the working registers, is reset so that an
    // aborted division leaves nothing behind and outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            rem     <= '0;
            q       <= '0;
            divisor <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                    if (accept) begin
                        if (bus.dataB != '0) begin
                            divisor <= bus.dataB;
                            q       <= bus.dataA;
                            rem     <= '0;
                            count   <= '0;
                            busy_r  <= 1'b1;
                            state   <= S_RUN;
                        end else begin
                            lo_r   <= '1;
                            hi_r   <= bus.dataA;
                            dz_r   <= 1'b1;
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    rem   <= rem_next;
                    q     <= q_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        // Last step: publish the finished result in one go.
                        lo_r   <= q_next;
                        hi_r   <= rem_next[WIDTH-1:0];
                        dz_r   <= 1'b0;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        count  <= '0;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dz   = dz_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_divu_unit.sv
// -----------------------------------------------------------------------------
// tb_divu_unit
// Self-checking bench for divu_unit: a vector table of divisions with
// hand-derived quotient/remainder, a scoreboard queue compared whenever done
// pulses, and directed sequences for ignored starts, back-to-back operation
// and reset during a division.
// -----------------------------------------------------------------------------
module tb_divu_unit;
    import alu_defs::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    divu_unit_if #(.WIDTH(32)) bus ();

    divu_unit #(.WIDTH(32), .DIVU(FN_DIVU)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] lo, input logic [31:0] hi, input logic dz);
        exp_t e;
        e.lo = lo;
        e.hi = hi;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Drive one request; returns #1 after the edge that samples it.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
        bus.dataA  = a;
        bus.dataB  = b;
        bus.signal = fn;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.signal = 6'd0;
    endtask

    // Called at a falling edge; counts rising edges until done is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (edges >= 100) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_vector(input vec_t v);
        int edges;
        @(negedge clk);
        push(v.lo, v.hi, v.dz);
        issue(v.a, v.b, FN_DIVU);
        @(negedge clk);
        check("busy_after_accept", {31'd0, bus.busy}, {31'd0, (v.b != 0)});
        wait_done(edges);
        check("latency", edges, (v.b != 0) ? 32'd32 : 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_falls", {31'd0, bus.done}, 32'd0);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            check("busy_with_done", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("lo", bus.lo, mon_e.lo);
                check("hi", bus.hi, mon_e.hi);
                check("dz", {31'd0, bus.dz}, {31'd0, mon_e.dz});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int edges;
        int extra_done;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0};
        vecs[2] = '{32'd7,          32'd100,        32'd0,          32'd7,    1'b0};
        vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,    1'b1};
        vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0};
        vecs[5] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,    1'b0};
        vecs[6] = '{32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'd1,          32'd0,    1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,    1'b0};
        vecs[8] = '{32'd305419896,  32'd10000,      32'd30541,      32'd9896, 1'b0};

        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.signal = '0;
        bus.start  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_dz",   {31'd0, bus.dz},   32'd0);
        check("rst_hi",   bus.hi, 32'd0);
        check("rst_lo",   bus.lo, 32'd0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) run_vector(vecs[i]);

        // start during RUN is ignored; the running result stays 1000/9.
        @(negedge clk);
        push(32'd111, 32'd1, 1'b0);
        issue(32'd1000, 32'd9, FN_DIVU);
        repeat (9) @(posedge clk);
        @(negedge clk);
        issue(32'd50, 32'd5, FN_DIVU);
        @(negedge clk);
        check("midrun_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(edges);
        check("midrun_latency", edges, 32'd22);
        @(posedge clk);
        @(negedge clk);

        // Non-DIVU codes in IDLE do nothing, including with a zero divisor.
        issue(32'd77, 32'd3, FN_ADD);
        issue(32'd5, 32'd0, FN_ADD);
        @(negedge clk);
        check("add_busy", {31'd0, bus.busy}, 32'd0);
        check("add_done", {31'd0, bus.done}, 32'd0);
        check("add_lo_hold", bus.lo, 32'd111);
        check("add_hi_hold", bus.hi, 32'd1);

        // Back-to-back: second request accepted in the DONE cycle.
        @(negedge clk);
        push(32'd14, 32'd2, 1'b0);
        issue(32'd100, 32'd7, FN_DIVU);
        @(negedge clk);
        wait_done(edges);
        push(32'd8, 32'd2, 1'b0);
        issue(32'd50, 32'd6, FN_DIVU);
        @(negedge clk);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_done_low", {31'd0, bus.done}, 32'd0);
        wait_done(edges);
        check("b2b_latency", edges, 32'd32);
        @(posedge clk);
        @(negedge clk);

        // Reset at step 15 aborts the division.
        push(32'd1234, 32'd5, 1'b0);
        issue(32'd12345, 32'd10, FN_DIVU);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_dz",   {31'd0, bus.dz},   32'd0);
        check("abort_hi",   bus.hi, 32'd0);
        check("abort_lo",   bus.lo, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
        end
        check("abort_no_done", extra_done, 32'd0);
        run_vector('{32'd81, 32'd9, 32'd9, 32'd0, 1'b0});

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
